// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit framer: FSM states, parity modes
// and the default baud divider.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // 50 MHz system clock divided down to 115200 baud.
  localparam int CLK_DIV_DEFAULT = 434;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Payload handshake and serial-line outputs of the UART transmit framer.
interface uart_tx_framer_if #(
  parameter int DATA_W = 8
);

  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_ready;
  logic              o_tx;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_valid, i_data,
    input  o_ready, o_tx, o_busy, o_done
  );

  modport slave (
    input  i_valid, i_data,
    output o_ready, o_tx, o_busy, o_done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Baud-period counter: wraps at CLK_DIV-1 and flags that last count with a
// one-cycle tick; a synchronous clear restarts the period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  output logic [$clog2(CLK_DIV)-1:0] o_cnt,
  output logic                       o_tick
);

  localparam int                CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: captures one payload per frame and serialises it as
// start, LSB-first data, optional parity and 1-2 stop bits.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = CLK_DIV_DEFAULT,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_framer_if.slave  bus
);

  localparam int                 BIT_W     = $clog2(DATA_W + 1);
  localparam int                 BAUD_W    = $clog2(CLK_DIV);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [BAUD_W-1:0] STOP_END  = BAUD_W'(CLK_DIV - 2);

  state_e             state_q, state_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               par_q, par_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0]  baud_cnt;
  logic               baud_tick;
  logic               accept;

  assign accept = bus.i_valid && (state_q == IDLE);

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .o_cnt  (baud_cnt),
    .o_tick (baud_tick)
  );

  // The last stop bit leaves one cycle early: its final cycle is the IDLE
  // cycle itself, where o_tx is still high and a new frame can be accepted.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    par_d     = par_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d   = START;
          tx_d      = 1'b0;
          shift_d   = bus.i_data;
          bit_cnt_d = '0;
          par_d     = (PARITY == PAR_ODD) ? ~^bus.i_data : ^bus.i_data;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[DATA_W-1:1]};
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[0];
            shift_d   = {1'b1, shift_q[DATA_W-1:1]};
          end
        end
      end
      PAR: begin
        if (baud_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if ((bit_cnt_q == LAST_STOP) && (baud_cnt == STOP_END)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (baud_tick) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      par_q     <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      par_q     <= par_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bus.o_tx    = tx_q;
  assign bus.o_done  = done_q;
  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: four parameterisations share clk/rst_n,
// frames are queued at issue time and checked cycle by cycle by a monitor.
module tb_uart_tx_framer;

  localparam int CDIV = 4;

  typedef struct {
    int          dut;
    logic [15:0] bits;
    int          nbits;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] valid_r = '0;
  logic [8:0] data_r [4] = '{default: '0};

  int n_vec  = 0;
  int n_miss = 0;

  frame_t      exp_q [$];
  frame_t      cur_f;
  logic [15:0] cur_bits [4];
  int          cur_len [4];
  int          cyc [4];
  bit          act [4];
  bit          acc_pend [4];
  bit          rst_seen;
  logic        e_tx, e_rdy, e_done;

  uart_tx_framer_if #(.DATA_W(8)) if0 ();
  uart_tx_framer_if #(.DATA_W(8)) if1 ();
  uart_tx_framer_if #(.DATA_W(8)) if2 ();
  uart_tx_framer_if #(.DATA_W(7)) if3 ();

  assign if0.i_valid = valid_r[0];
  assign if1.i_valid = valid_r[1];
  assign if2.i_valid = valid_r[2];
  assign if3.i_valid = valid_r[3];
  assign if0.i_data  = data_r[0][7:0];
  assign if1.i_data  = data_r[1][7:0];
  assign if2.i_data  = data_r[2][7:0];
  assign if3.i_data  = data_r[3][6:0];

  wire [3:0] tx_w   = {if3.o_tx,    if2.o_tx,    if1.o_tx,    if0.o_tx};
  wire [3:0] rdy_w  = {if3.o_ready, if2.o_ready, if1.o_ready, if0.o_ready};
  wire [3:0] busy_w = {if3.o_busy,  if2.o_busy,  if1.o_busy,  if0.o_busy};
  wire [3:0] done_w = {if3.o_done,  if2.o_done,  if1.o_done,  if0.o_done};

  uart_tx_framer #(.DATA_W(8), .CLK_DIV(CDIV), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  uart_tx_framer #(.DATA_W(8), .CLK_DIV(CDIV), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  uart_tx_framer #(.DATA_W(8), .CLK_DIV(CDIV), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));
  uart_tx_framer #(.DATA_W(7), .CLK_DIV(CDIV), .PARITY(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3));

  initial forever #5 clk = ~clk;

  task automatic check_output(input string name, input int d, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("[TB] FAIL %s dut%0d t=%0t got %b want %b", name, d, $time, got, want);
    end
  endtask

  task automatic apply_stimulus(input int d, input logic [8:0] data,
                                input logic [15:0] bits, input int nbits);
    frame_t f;
    f.dut   = d;
    f.bits  = bits;
    f.nbits = nbits;
    exp_q.push_back(f);
    valid_r[d] = 1'b1;
    data_r[d]  = data;
    @(posedge clk); #1;
    valid_r[d] = 1'b0;
    data_r[d]  = ~data;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: cycle 1 is the first cycle after the accept edge; the
  // frame's last cycle is the IDLE/done cycle, still showing the stop level.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (!rst_seen) begin
          act[d] = 1'b0;
        end else if (acc_pend[d]) begin
          n_vec++;
          if (exp_q.size() == 0 || exp_q[0].dut != d) begin
            n_miss++;
            $display("[TB] FAIL accept dut%0d t=%0t got unqueued accept want queued frame", d, $time);
            act[d] = 1'b0;
          end else begin
            cur_f       = exp_q.pop_front();
            cur_bits[d] = cur_f.bits;
            cur_len[d]  = cur_f.nbits * CDIV;
            cyc[d]      = 1;
            act[d]      = 1'b1;
          end
        end else if (act[d]) begin
          if (cyc[d] == cur_len[d]) act[d] = 1'b0;
          else cyc[d]++;
        end
        if (act[d]) begin
          e_tx   = cur_bits[d][(cyc[d] - 1) / CDIV];
          e_rdy  = (cyc[d] == cur_len[d]);
          e_done = e_rdy;
        end else begin
          e_tx   = 1'b1;
          e_rdy  = 1'b1;
          e_done = 1'b0;
        end
        check_output("o_tx",    d, tx_w[d],   e_tx);
        check_output("o_ready", d, rdy_w[d],  e_rdy);
        check_output("o_busy",  d, busy_w[d], !e_rdy);
        check_output("o_done",  d, done_w[d], e_done);
        acc_pend[d] = rst_n && valid_r[d] && e_rdy;
      end
      rst_seen = rst_n;
    end
  end

  initial begin
    $display("[TB] uart_tx_framer scoreboard bench");
    idle_wait(3);
    rst_n = 1'b1;
    idle_wait(2);

    // 8N1 0xA5, then even/odd parity variants of 0xA5 and 0x07
    apply_stimulus(0, 9'h0A5, 16'h034A, 10); idle_wait(44);
    apply_stimulus(1, 9'h0A5, 16'h054A, 11); idle_wait(48);
    apply_stimulus(2, 9'h0A5, 16'h074A, 11); idle_wait(48);
    apply_stimulus(1, 9'h007, 16'h060E, 11); idle_wait(48);
    apply_stimulus(2, 9'h007, 16'h040E, 11); idle_wait(48);

    // 7N2 frames
    apply_stimulus(3, 9'h07F, 16'h03FE, 10); idle_wait(44);
    apply_stimulus(3, 9'h02A, 16'h0354, 10); idle_wait(44);

    // back-to-back: valid held across the done cycle
    begin
      frame_t f;
      f.dut = 0; f.bits = 16'h02AA; f.nbits = 10;
      exp_q.push_back(f);
      valid_r[0] = 1'b1;
      data_r[0]  = 9'h055;
      @(posedge clk); #1;
      data_r[0] = 9'h00F;
      f.bits = 16'h021E;
      exp_q.push_back(f);
      repeat (40) @(posedge clk);
      #1;
      valid_r[0] = 1'b0;
      data_r[0]  = '0;
      idle_wait(44);
    end

    // mid-frame valid pulse and data change must be ignored
    apply_stimulus(0, 9'h03C, 16'h0278, 10);
    idle_wait(10);
    valid_r[0] = 1'b1;
    data_r[0]  = 9'h0FF;
    @(posedge clk); #1;
    valid_r[0] = 1'b0;
    data_r[0]  = 9'h0AA;
    idle_wait(45);

    // reset during data bit 3, then accept on the first cycle after release
    apply_stimulus(0, 9'h0C3, 16'h0386, 10);
    idle_wait(18);
    rst_n = 1'b0;
    idle_wait(2);
    rst_n = 1'b1;
    apply_stimulus(0, 9'h081, 16'h0302, 10);
    idle_wait(45);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL queue_drain got %0d pending frames want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
